// File: rtl/keypad_scanner.sv
// Matrix keypad front end: drives column strobes, debounces whole scan frames,
// rejects multi-key patterns and queues press/repeat events in a one-deep valid/ready register.
module keypad_scanner #(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_RATE     = 4,
    localparam int unsigned CODE_W         = $clog2(ROWS * COLS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROWS-1:0]   row_n,
    output logic [COLS-1:0]   col_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_rep,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overflow
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned RMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_e;

    logic [ROWS-1:0]   row_s1_q, row_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COLS-1:0]   col_n_q, col_n_d;
    logic              acc_hit_q, acc_hit_d, acc_multi_q, acc_multi_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;
    logic              frame_end_q, frame_end_d;
    logic              frm_stb_q, frm_stb_d;
    res_e              frm_kind_q, frm_kind_d;
    logic [CODE_W-1:0] frm_code_q, frm_code_d;
    res_e              cand_kind_q, cand_kind_d;
    logic [CODE_W-1:0] cand_code_q, cand_code_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    res_e              stab_kind_q, stab_kind_d;
    logic [CODE_W-1:0] stab_code_q, stab_code_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              held_q, held_d;
    logic              kv_q, kv_d, krep_q, krep_d, ovf_q, ovf_d;
    logic [CODE_W-1:0] kcode_q, kcode_d;

    logic              div_last, col_last;
    logic              smp_seen, smp_multi;
    logic [ROW_W-1:0]  smp_row;
    logic [CODE_W-1:0] smp_code;
    logic              same, accept, ev, ev_rep;
    logic [CODE_W-1:0] ev_code;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_s1_q    <= '1;
            row_s2_q    <= '1;
            div_q       <= '0;
            col_q       <= '0;
            col_n_q     <= ~COLS'(1);
            acc_hit_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= '0;
            frame_end_q <= 1'b0;
            frm_stb_q   <= 1'b0;
            frm_kind_q  <= RES_NONE;
            frm_code_q  <= '0;
            cand_kind_q <= RES_NONE;
            cand_code_q <= '0;
            deb_cnt_q   <= '0;
            stab_kind_q <= RES_NONE;
            stab_code_q <= '0;
            tmr_q       <= '0;
            held_q      <= 1'b0;
            kv_q        <= 1'b0;
            kcode_q     <= '0;
            krep_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            row_s1_q    <= row_n;
            row_s2_q    <= row_s1_q;
            div_q       <= div_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            acc_hit_q   <= acc_hit_d;
            acc_multi_q <= acc_multi_d;
            acc_code_q  <= acc_code_d;
            frame_end_q <= frame_end_d;
            frm_stb_q   <= frm_stb_d;
            frm_kind_q  <= frm_kind_d;
            frm_code_q  <= frm_code_d;
            cand_kind_q <= cand_kind_d;
            cand_code_q <= cand_code_d;
            deb_cnt_q   <= deb_cnt_d;
            stab_kind_q <= stab_kind_d;
            stab_code_q <= stab_code_d;
            tmr_q       <= tmr_d;
            held_q      <= held_d;
            kv_q        <= kv_d;
            kcode_q     <= kcode_d;
            krep_q      <= krep_d;
            ovf_q       <= ovf_d;
        end
    end

    // Classify the synchronised rows of the current column: none, one, or several low.
    always_comb begin
        smp_seen  = 1'b0;
        smp_multi = 1'b0;
        smp_row   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_s2_q[r]) begin
                if (smp_seen) smp_multi = 1'b1;
                smp_seen = 1'b1;
                smp_row  = ROW_W'(r);
            end
        end
    end

    assign smp_code = CODE_W'(32'(smp_row) * COLS + 32'(col_q));

    // Column scan and per-frame hit accumulation; the frame result is latched one clock after the last sample.
    always_comb begin
        div_last    = (div_q == DIV_W'(SCAN_DIV - 1));
        col_last    = (col_q == COL_W'(COLS - 1));
        div_d       = div_last ? '0 : div_q + DIV_W'(1);
        col_d       = col_q;
        if (div_last) col_d = col_last ? '0 : col_q + COL_W'(1);
        col_n_d     = ~(COLS'(1) << col_d);
        acc_hit_d   = acc_hit_q;
        acc_multi_d = acc_multi_q;
        acc_code_d  = acc_code_q;
        frame_end_d = div_last && col_last;
        frm_stb_d   = frame_end_q;
        frm_kind_d  = frm_kind_q;
        frm_code_d  = frm_code_q;
        if (frame_end_q) begin
            frm_kind_d  = acc_multi_q ? RES_MULTI : (acc_hit_q ? RES_SINGLE : RES_NONE);
            frm_code_d  = acc_code_q;
            acc_hit_d   = 1'b0;
            acc_multi_d = 1'b0;
            acc_code_d  = '0;
        end
        if (div_last) begin
            if (smp_multi || (smp_seen && acc_hit_q)) begin
                acc_multi_d = 1'b1;
            end else if (smp_seen) begin
                acc_hit_d  = 1'b1;
                acc_code_d = smp_code;
            end
        end
    end

    // Frame debounce, stable-state transitions and the typematic countdown (frozen while candidate is MULTI).
    always_comb begin
        cand_kind_d = cand_kind_q;
        cand_code_d = cand_code_q;
        deb_cnt_d   = deb_cnt_q;
        stab_kind_d = stab_kind_q;
        stab_code_d = stab_code_q;
        tmr_d       = tmr_q;
        same        = 1'b0;
        accept      = 1'b0;
        ev          = 1'b0;
        ev_code     = stab_code_q;
        ev_rep      = 1'b0;
        if (frm_stb_q) begin
            same = (frm_kind_q == cand_kind_q) &&
                   ((frm_kind_q != RES_SINGLE) || (frm_code_q == cand_code_q));
            if (same) begin
                if (deb_cnt_q < DEB_W'(DEBOUNCE_FRAMES)) deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end else begin
                cand_kind_d = frm_kind_q;
                cand_code_d = frm_code_q;
                deb_cnt_d   = DEB_W'(1);
            end
            accept = (deb_cnt_d == DEB_W'(DEBOUNCE_FRAMES));
            if (cand_kind_d != RES_MULTI) begin
                if (accept && (cand_kind_d == RES_SINGLE) &&
                    ((stab_kind_q != RES_SINGLE) || (stab_code_q != cand_code_d))) begin
                    stab_kind_d = RES_SINGLE;
                    stab_code_d = cand_code_d;
                    tmr_d       = TMR_W'(REPEAT_DELAY);
                    ev          = 1'b1;
                    ev_code     = cand_code_d;
                end else if (accept && (cand_kind_d == RES_NONE)) begin
                    stab_kind_d = RES_NONE;
                    tmr_d       = '0;
                end else if ((REPEAT_EN != 0) && (stab_kind_q == RES_SINGLE)) begin
                    if (tmr_q <= TMR_W'(1)) begin
                        ev      = 1'b1;
                        ev_rep  = 1'b1;
                        tmr_d   = TMR_W'(REPEAT_RATE);
                    end else begin
                        tmr_d   = tmr_q - TMR_W'(1);
                    end
                end
            end
        end
        held_d = (stab_kind_d == RES_SINGLE);
    end

    // One-deep event register; an event meeting a stalled full register is dropped and flagged.
    always_comb begin
        kv_d    = kv_q;
        kcode_d = kcode_q;
        krep_d  = krep_q;
        ovf_d   = ovf_q;
        if (ev) begin
            if (!kv_q || key_ready) begin
                kv_d    = 1'b1;
                kcode_d = ev_code;
                krep_d  = ev_rep;
            end else begin
                ovf_d   = 1'b1;
            end
        end else if (kv_q && key_ready) begin
            kv_d = 1'b0;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = kcode_q;
    assign key_rep   = krep_q;
    assign key_valid = kv_q;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: an ideal 4x4 key matrix feeds two instances (repeat off / on);
// frame-level vector table, corner-case sequences and a random run against a frame model.
module tb_keypad_scanner;

    localparam int DEB    = 3;
    localparam int RDELAY = 8;
    localparam int RRATE  = 4;
    localparam int NONE   = -1;
    localparam int MULTI  = -2;
    localparam int NRAND  = 300;

    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K15 = 16'h8000;
    localparam logic [15:0] KG  = 16'h0202;

    typedef struct {
        int code;
        int rep;
        int frame;
    } ev_t;

    typedef struct {
        logic [15:0] keys;
        bit          held;
        bit          ev;
        int          code;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_ready = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  row_a, row_b, col_a, col_b, code_a, code_b;
    logic        rep_a, rep_b, valid_a, valid_b, held_a, held_b, ovf_a, ovf_b;

    int   checks = 0;
    int   failures = 0;
    int   frame_idx = 0;
    ev_t  q_a[$];
    ev_t  q_b[$];
    vec_t tbl[$];
    int   hist[$];
    int   m_stable[2];
    int   m_n[2];
    bit   p_ev[2];
    bit   p_held[2];
    int   p_code[2];
    int   p_rep[2];

    always #5 clock = ~clock;

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(DEB), .REPEAT_EN(0),
                     .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)) dut_a (
        .clock(clock), .reset(reset), .row_n(row_a), .col_n(col_a), .key_code(code_a),
        .key_rep(rep_a), .key_valid(valid_a), .key_ready(key_ready), .key_held(held_a),
        .overflow(ovf_a));

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(DEB), .REPEAT_EN(1),
                     .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)) dut_b (
        .clock(clock), .reset(reset), .row_n(row_b), .col_n(col_b), .key_code(code_b),
        .key_rep(rep_b), .key_valid(valid_b), .key_ready(key_ready), .key_held(held_b),
        .overflow(ovf_b));

    // Ideal matrix: a row reads low while the strobed column has a pressed key on it.
    function automatic logic [3:0] rows_for(input logic [15:0] k, input logic [3:0] coln);
        logic [3:0] r;
        r = '1;
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
                if (k[rr*4+c] && !coln[c]) r[rr] = 1'b0;
        return r;
    endfunction

    assign row_a = rows_for(keys, col_a);
    assign row_b = rows_for(keys, col_b);

    always @(negedge clock) begin
        if (!reset && valid_a && key_ready) q_a.push_back('{int'(code_a), int'(rep_a), frame_idx - 1});
        if (!reset && valid_b && key_ready) q_b.push_back('{int'(code_b), int'(rep_b), frame_idx - 1});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        keys  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
        frame_idx = 0;
    endtask

    // Events handed over during the current frame must be exactly those the previous frame produced.
    task automatic check_ev(input int which, input bit exp_ev, input int code, input int rep,
                            input int frm, input string tag);
        ev_t e;
        int  n;
        n = (which == 0) ? q_a.size() : q_b.size();
        if (!exp_ev) begin
            chk($sformatf("%s%0d_no_event", tag, frm), n, 0);
        end else begin
            chk($sformatf("%s%0d_event_count", tag, frm), n, 1);
            if (n > 0) begin
                if (which == 0) e = q_a.pop_front();
                else            e = q_b.pop_front();
                chk($sformatf("%s%0d_code", tag, frm), e.code, code);
                chk($sformatf("%s%0d_rep", tag, frm), e.rep, rep);
                chk($sformatf("%s%0d_frame", tag, frm), e.frame, frm);
            end
        end
        if (which == 0) q_a.delete();
        else            q_b.delete();
    endtask

    task automatic add(input logic [15:0] k, input bit held, input bit ev, input int code);
        tbl.push_back('{k, held, ev, code});
    endtask

    task automatic model_reset();
        hist.delete();
        for (int m = 0; m < 2; m++) begin
            m_stable[m] = NONE;
            m_n[m]      = 0;
        end
    endtask

    // Frame-level model: accept a result once it has been seen DEB frames in a row.
    task automatic model_frame(input logic [15:0] k);
        int res, run;
        res = NONE;
        if ($countones(k) > 1) res = MULTI;
        else for (int j = 0; j < 16; j++) if (k[j]) res = j;
        hist.push_back(res);
        run = 0;
        for (int j = hist.size() - 1; j >= 0; j--) begin
            if (hist[j] != res || run >= DEB) break;
            run++;
        end
        for (int m = 0; m < 2; m++) begin
            p_ev[m]   = 1'b0;
            p_code[m] = 0;
            p_rep[m]  = 0;
            if (res != MULTI && run >= DEB && res != m_stable[m]) begin
                if (res >= 0) begin
                    p_ev[m]   = 1'b1;
                    p_code[m] = res;
                    m_n[m]    = 0;
                end
                m_stable[m] = res;
            end else if (m == 1 && m_stable[m] >= 0 && res != MULTI) begin
                m_n[m]++;
                if (m_n[m] >= RDELAY && (m_n[m] - RDELAY) % RRATE == 0) begin
                    p_ev[m]   = 1'b1;
                    p_code[m] = m_stable[m];
                    p_rep[m]  = 1;
                end
            end
            p_held[m] = (m_stable[m] >= 0);
        end
    endtask

    function automatic logic [15:0] next_keys(input logic [15:0] prev);
        logic [15:0] k;
        int sel, b1, b2;
        sel = int'($urandom_range(0, 9));
        k   = '0;
        if (sel <= 5) begin
            k = prev;
        end else if (sel <= 8 && sel >= 7) begin
            b1 = int'($urandom_range(0, 15));
            k[b1] = 1'b1;
        end else if (sel == 9) begin
            b1 = int'($urandom_range(0, 15));
            b2 = (b1 + int'($urandom_range(1, 15))) % 16;
            k[b1] = 1'b1;
            k[b2] = 1'b1;
        end
        return k;
    endfunction

    initial begin
        // Press, bounce, ghost rejection and release, one record per frame.
        for (int i = 0; i < 10; i++) add(K6, i >= 2, i == 2, 6);
        add('0, 1, 0, 0); add('0, 1, 0, 0); add('0, 0, 0, 0); add('0, 0, 0, 0);
        add(K6, 0, 0, 0); add('0, 0, 0, 0); add(K6, 0, 0, 0); add(K6, 0, 0, 0);
        add(K6, 1, 1, 6); add(K6, 1, 0, 0);
        add('0, 1, 0, 0); add('0, 1, 0, 0); add('0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(KG, 0, 0, 0);
        add(K5, 0, 0, 0); add(K5, 0, 0, 0); add(K5, 1, 1, 5);
        for (int i = 0; i < 6; i++) add(KG, 1, 0, 0);
        add(K5, 1, 0, 0); add(K5, 1, 0, 0); add(K5, 1, 0, 0);
        add('0, 1, 0, 0); add('0, 1, 0, 0); add('0, 0, 0, 0);

        do_reset();
        chk("reset_col_n", int'(col_a), 14);
        chk("reset_key_code", int'(code_a), 0);
        chk("reset_key_rep", int'(rep_a), 0);
        chk("reset_key_valid", int'(valid_a), 0);
        chk("reset_key_held", int'(held_a), 0);
        chk("reset_overflow", int'(ovf_a), 0);

        for (int i = 0; i <= tbl.size(); i++) begin
            frame_idx = i;
            keys = (i < tbl.size()) ? tbl[i].keys : tbl[tbl.size()-1].keys;
            half();
            if (i > 0) begin
                chk($sformatf("tbl%0d_held", i - 1), int'(held_a), int'(tbl[i-1].held));
                chk($sformatf("tbl%0d_valid_mid", i - 1), int'(valid_a), 0);
                check_ev(0, tbl[i-1].ev, tbl[i-1].code, 0, i - 1, "tbl");
            end
            half();
        end

        // Typematic repeat: press at frame 2, repeats 8, 12, 16, 20 frames later, none after release.
        do_reset();
        for (int i = 0; i <= 27; i++) begin
            int f;
            bit rev;
            frame_idx = i;
            keys = (i < 23) ? K15 : '0;
            half();
            if (i > 0) begin
                f   = i - 1;
                rev = (f == 10) || (f == 14) || (f == 18) || (f == 22);
                chk($sformatf("rpt%0d_held", f), int'(held_b), int'(f >= 2 && f <= 24));
                check_ev(1, (f == 2) || rev, 15, int'(rev), f, "rpt");
            end
            half();
        end

        // Backpressure: first event held, second dropped with sticky overflow.
        do_reset();
        key_ready = 1'b0;
        for (int i = 0; i <= 9; i++) begin
            frame_idx = i;
            keys = (i <= 2) ? K3 : ((i <= 5) ? '0 : K5);
            half();
            if (i == 8) begin
                chk("bp_valid_before_drop", int'(valid_a), 1);
                chk("bp_overflow_before_drop", int'(ovf_a), 0);
            end
            if (i == 9) begin
                chk("bp_valid_held", int'(valid_a), 1);
                chk("bp_code_held", int'(code_a), 3);
                chk("bp_rep_held", int'(rep_a), 0);
                chk("bp_overflow_set", int'(ovf_a), 1);
                chk("bp_held_code5", int'(held_a), 1);
                chk("bp_no_handshake", q_a.size(), 0);
                key_ready = 1'b1;
                @(posedge clock);
                #1;
                key_ready = 1'b0;
                chk("bp_valid_drop", int'(valid_a), 0);
                chk("bp_overflow_sticky", int'(ovf_a), 1);
                chk("bp_one_handshake", q_a.size(), 1);
                if (q_a.size() > 0) chk("bp_handshake_code", q_a[0].code, 3);
                q_a.delete();
            end
            half();
        end

        // Mid-frame reset while an event is pending and code 9 is stable.
        for (int i = 10; i <= 13; i++) begin
            frame_idx = i;
            keys = K9;
            half();
            if (i < 13) half();
        end
        chk("rst_pre_valid", int'(valid_a), 1);
        chk("rst_pre_code", int'(code_a), 9);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_col_n", int'(col_a), 14);
        chk("rst_key_code", int'(code_a), 0);
        chk("rst_key_rep", int'(rep_a), 0);
        chk("rst_key_valid", int'(valid_a), 0);
        chk("rst_key_held", int'(held_a), 0);
        chk("rst_overflow", int'(ovf_a), 0);
        q_a.delete();
        q_b.delete();
        key_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            frame_idx = i;
            keys = K9;
            half();
            if (i > 0) begin
                chk($sformatf("rst%0d_held", i - 1), int'(held_a), int'(i - 1 >= 2));
                check_ev(0, i - 1 == 2, 9, 0, i - 1, "rst");
            end
            half();
        end

        // Random frame patterns against the frame model, both instances.
        do_reset();
        model_reset();
        key_ready = 1'b1;
        for (int i = 0; i <= NRAND; i++) begin
            frame_idx = i;
            keys = (i < NRAND) ? next_keys(keys) : '0;
            half();
            if (i > 0) begin
                chk($sformatf("rnd%0d_held_a", i - 1), int'(held_a), int'(p_held[0]));
                chk($sformatf("rnd%0d_held_b", i - 1), int'(held_b), int'(p_held[1]));
                check_ev(0, p_ev[0], p_code[0], p_rep[0], i - 1, "rnd_a");
                check_ev(1, p_ev[1], p_code[1], p_rep[1], i - 1, "rnd_b");
            end
            model_frame(keys);
            half();
        end
        chk("rnd_overflow_a", int'(ovf_a), 0);
        chk("rnd_overflow_b", int'(ovf_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad front end. It drives the column strobes itself and samples ROWS×COLS active-low rows. It debounces a whole scan frame at a time, rejects multi-key/ghost patterns, and delivers key events (press and optional typematic repeat) through a one-deep valid/ready output register. It sits between the keypad pins and the hex/command logic that consumes 4-bit key codes, and supersedes the fixed 4×4 encoder that relied on an external column counter.

## Interface
- ROWS, 4, number of row inputs (≥2)
- COLS, 4, number of column strobes (≥2)
- SCAN_DIV, 4, clocks each column is driven before its rows are sampled (≥4)
- DEBOUNCE_FRAMES, 3, consecutive identical frames needed to accept a new state (≥1)
- REPEAT_EN, 0, 1 enables typematic repeat events
- REPEAT_DELAY, 8, frames from accepted press to first repeat (≥1)
- REPEAT_RATE, 4, frames between subsequent repeats (≥1)
- CODE_W, $clog2(ROWS*COLS), derived key-code width (localparam)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- row_n  in  ROWS  keypad rows, active-low, asynchronous (2-flop synchronised internally)
- col_n  out  COLS  column strobes, active-low one-hot
- key_code  out  CODE_W  code of pending event = row*COLS + col
- key_rep  out  1  pending event is a repeat (0 = fresh press)
- key_valid  out  1  event pending
- key_ready  in  1  consumer accepts event when key_valid && key_ready
- key_held  out  1  debounced state is a single key down
- overflow  out  1  sticky: an event was dropped

## Operation
- Scan: a column counter advances every SCAN_DIV clocks, wrapping COLS-1→0; col_n = ~(1<<col). A frame is one full pass of columns 0..COLS-1.
- Sample: on the last dwell clock of each column, take the synchronised rows. 0 rows low → nothing. 1 row low → record (row,col). ≥2 rows low → mark frame multi.
- Frame result: NONE (no hits), SINGLE(code) (exactly one hit in the frame), MULTI (more than one hit, any columns).
- Debounce: keep a candidate result and a saturating counter. A frame equal to the candidate increments the counter; a different frame replaces the candidate and sets the counter to 1. When the counter reaches DEBOUNCE_FRAMES, the candidate is accepted as stable.
- Stable transitions:
  - NONE→SINGLE(c), or SINGLE(a)→SINGLE(c≠a): press event c, key_rep=0.
  - SINGLE→NONE: key_held←0, no event.
  - Candidate MULTI is never accepted: stable state and key_held are unchanged, and the repeat timer freezes.
- key_held = (stable == SINGLE).
- Repeat (REPEAT_EN=1): a frame counter restarts at each accepted press. The first repeat event (same code, key_rep=1) fires REPEAT_DELAY frames after the press, then every REPEAT_RATE frames while stable SINGLE persists. Release or a code change cancels repeats.
- Output register:
  - An event loads when key_valid=0, or when key_valid && key_ready in the same cycle (the new event replaces the accepted one and key_valid stays 1).
  - key_valid falls on handshake when no new event arrives.
  - An event arriving while key_valid && !key_ready is dropped and sets overflow. The held event is unchanged.
  - overflow clears only on reset.

## Timing
- Reset values: col_n = ~1 (column 0 driven); key_code=0, key_rep=0, key_valid=0, key_held=0, overflow=0. Scan, debounce and repeat counters = 0, candidate and stable = NONE, synchronisers = all 1s.
- Reset mid-frame abandons the frame and all debounce/repeat history. After release, scanning restarts at column 0.
- Frame length = COLS×SCAN_DIV clocks.
- Frame result is registered 1 clock after the last column's sample. key_valid and key_held update 1 clock later, i.e. 2 clocks after that sample.
- Minimum press-to-event latency is DEBOUNCE_FRAMES frames + 2 clocks, plus synchroniser delay (2 clocks, absorbed in the dwell).
- key_code and key_rep are stable whenever key_valid=1. At most one event is produced per frame.

## Test plan
Parameters: ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-clock frame).

1. key_ready=1; hold row 1 low whenever column 2 is driven, for 10 frames, then release → exactly one event (code 6, key_rep=0). key_held=1 from end of frame 3, key_held=0 3 frames after release, no release event.
2. Bounce: code 6 for 1 frame, NONE for 1 frame, code 6 for 2 frames, then steady → one code-6 event, accepted at the end of the 3rd consecutive steady code-6 frame.
3. Ghost: rows 0 and 2 low in column 1, held 6 frames, with stable NONE → no event, key_held=0. Repeat with code 5 already stable → key_held stays 1, no event.
4. REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_RATE=4; hold code 15 for 20 frames after acceptance → press event plus repeats at frames 8, 12, 16, 20 (key_rep=1, code 15). Release → no further events.
5. Backpressure: key_ready=0; press code 3 (accepted), release, then press code 5 → key_valid=1 with code 3, overflow=1, code 5 lost. Raise key_ready for 1 clock → key_valid=0 next clock, overflow remains 1.
6. Reset pulsed for 1 clock mid-frame while code 9 is stable → next clock col_n=4'b1110 and all outputs 0. Holding code 9 yields a fresh press event after 3 frames.
